lvds_tx_framer_gearbox: RTL and testbench

Transmit-side LVDS link block: frames 10-bit pixel lines with sync words and converts the 10-bit word stream into a continuous 6-bit chunk stream for an OSERDES2 cascade running at serialization factor 6. It runs on the divided global clock, the ×1/6 output of the PLL/BUFPLL pair. It is the counterpart of the 6:1 receive deserializer path, and serves as the sensor-emulator / loopback transmitter.

---
 rtl/lvds_tx_framer_gearbox_pkg.sv | 26 ++
 rtl/lvds_tx_framer_gearbox_if.sv | 14 +
 rtl/lvds_tx_framer_gearbox_gearbox.sv | 47 ++++
 rtl/lvds_tx_framer_gearbox.sv | 133 +++++++++++++
 tb/tb_lvds_tx_framer_gearbox.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lvds_tx_framer_gearbox_pkg.sv
// Shared definitions for the LVDS transmit framer: word/chunk widths,
// default framing codes and the framer state encoding.
// Optional feature macro: LVDS_TX_CRC_EN adds the per-line checksum state.
package lvds_link_pkg;

  localparam int DATA_W = 10;
  localparam int SER_W  = 6;
  localparam int BUF_W  = 16;

  localparam logic [DATA_W-1:0] DEF_TRAIN_WORD = 10'h3A6;
  localparam logic [DATA_W-1:0] DEF_SOL_WORD   = 10'h2AA;
  localparam logic [DATA_W-1:0] DEF_EOL_WORD   = 10'h155;
  localparam logic [DATA_W-1:0] DEF_FILL_WORD  = 10'h000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PIXEL = 2'd1,
`ifdef LVDS_TX_CRC_EN
    ST_EOL   = 2'd2,
    ST_CRC   = 2'd3
`else
    ST_EOL   = 2'd2
`endif
  } tx_state_e;

endpackage

// File: rtl/lvds_tx_framer_gearbox_if.sv
// Pixel word stream into the transmit framer (valid/ready handshake).
// The source holds s_data/s_last while s_valid is high until accepted.
interface lvds_tx_framer_gearbox_if;
  import lvds_link_pkg::*;

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_last;
  logic              s_ready;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);

endinterface

// File: rtl/lvds_tx_framer_gearbox_gearbox.sv
// 10-to-6 gearbox: appends a 10-bit word LSB-first into a 16-bit bit buffer
// whenever fewer than 6 bits are held, and emits 6 bits every cycle.
// load_slot_o tells the framer when the word input is taken this cycle.
module tx_gearbox_10to6
  import lvds_link_pkg::*;
(
  input  logic              gclk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] word_i,
  output logic              load_slot_o,
  output logic [SER_W-1:0]  ser_data_o
);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] merged;
  logic [3:0]       cnt_q, cnt_d;
  logic [SER_W-1:0] ser_q, ser_d;

  assign load_slot_o = (cnt_q < 4'd6);
  assign ser_data_o  = ser_q;

  // Append on load slots, take the low chunk, shift the remainder down.
  always_comb begin
    merged = buf_q;
    cnt_d  = cnt_q - 4'd6;
    if (load_slot_o) begin
      merged = buf_q | ({{(BUF_W-DATA_W){1'b0}}, word_i} << cnt_q);
      cnt_d  = cnt_q + 4'd4;
    end
    ser_d = merged[SER_W-1:0];
    buf_d = merged >> SER_W;
  end

  // Buffer, occupancy and output chunk registers.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      buf_q <= '0;
      cnt_q <= '0;
      ser_q <= '0;
    end else begin
      buf_q <= buf_d;
      cnt_q <= cnt_d;
      ser_q <= ser_d;
    end
  end

endmodule

// File: rtl/lvds_tx_framer_gearbox.sv
// LVDS transmit framer: wraps pixel lines in SOL/EOL words, fills idle time
// with training words, substitutes FILL on pixel underrun, and feeds the
// 10-to-6 gearbox that drives the OSERDES2 chunk stream.
// Optional feature macro: LVDS_TX_CRC_EN appends a sum-mod-1024 checksum word
// after EOL; line_done then marks the checksum word instead of EOL.
module lvds_tx_framer_gearbox
  import lvds_link_pkg::*;
#(
  parameter logic [DATA_W-1:0] TRAIN_WORD = DEF_TRAIN_WORD,
  parameter logic [DATA_W-1:0] SOL_WORD   = DEF_SOL_WORD,
  parameter logic [DATA_W-1:0] EOL_WORD   = DEF_EOL_WORD,
  parameter logic [DATA_W-1:0] FILL_WORD  = DEF_FILL_WORD
) (
  input  logic                      gclk,
  input  logic                      rst_n,
  lvds_tx_framer_gearbox_if.slave   pix_if,
  output logic [SER_W-1:0]          ser_data,
  output logic                      underrun,
  output logic                      line_done
);

  tx_state_e         state_q, state_d;
  logic              load_slot;
  logic [DATA_W-1:0] word;
  logic              s_ready_c;
  logic              underrun_d, underrun_q;
  logic              line_done_d, line_done_q;

`ifdef LVDS_TX_CRC_EN
  logic              sol_load;
  logic              consume;
  logic [DATA_W-1:0] crc_q, crc_d;
`endif

  tx_gearbox_10to6 u_gearbox (
    .gclk        (gclk),
    .rst_n       (rst_n),
    .word_i      (word),
    .load_slot_o (load_slot),
    .ser_data_o  (ser_data)
  );

  // Framer state register.
  always_ff @(posedge gclk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next state: the framer only moves when the gearbox takes a word.
  always_comb begin
    state_d = state_q;
    if (load_slot) begin
      case (state_q)
        ST_IDLE:  if (pix_if.s_valid) state_d = ST_PIXEL;
        ST_PIXEL: if (pix_if.s_valid && pix_if.s_last) state_d = ST_EOL;
`ifdef LVDS_TX_CRC_EN
        ST_EOL:   state_d = ST_CRC;
        ST_CRC:   state_d = ST_IDLE;
`else
        ST_EOL:   state_d = ST_IDLE;
`endif
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Word selection, handshake and status pulses from registered state.
  always_comb begin
    word        = TRAIN_WORD;
    s_ready_c   = rst_n & (state_q == ST_PIXEL) & load_slot;
    underrun_d  = 1'b0;
    line_done_d = 1'b0;
    case (state_q)
      ST_IDLE:  if (pix_if.s_valid) word = SOL_WORD;
      ST_PIXEL: begin
        if (pix_if.s_valid) begin
          word = pix_if.s_data;
        end else begin
          word       = FILL_WORD;
          underrun_d = load_slot;
        end
      end
`ifdef LVDS_TX_CRC_EN
      ST_EOL:   word = EOL_WORD;
      ST_CRC: begin
        word        = crc_q;
        line_done_d = load_slot;
      end
`else
      ST_EOL: begin
        word        = EOL_WORD;
        line_done_d = load_slot;
      end
`endif
      default:  word = TRAIN_WORD;
    endcase
  end

  assign pix_if.s_ready = s_ready_c;

  // Status pulses are registered so they line up with the first output chunk.
  always_ff @(posedge gclk) begin
    if (!rst_n) begin
      underrun_q  <= 1'b0;
      line_done_q <= 1'b0;
    end else begin
      underrun_q  <= underrun_d;
      line_done_q <= line_done_d;
    end
  end

  assign underrun  = underrun_q;
  assign line_done = line_done_q;

`ifdef LVDS_TX_CRC_EN
  assign sol_load = load_slot & (state_q == ST_IDLE) & pix_if.s_valid;
  assign consume  = pix_if.s_valid & s_ready_c;

  // Checksum: cleared as SOL goes out, accumulates only accepted pixels.
  always_comb begin
    crc_d = crc_q;
    if (sol_load)     crc_d = '0;
    else if (consume) crc_d = crc_q + pix_if.s_data;
  end

  // Checksum register.
  always_ff @(posedge gclk) begin
    if (!rst_n) crc_q <= '0;
    else        crc_q <= crc_d;
  end
`endif

endmodule

// File: tb/tb_lvds_tx_framer_gearbox.sv
// Bench for lvds_tx_framer_gearbox: a reference framer model pushes expected
// words into a scoreboard at each load slot; the output chunks are reassembled
// into 10-bit words and popped against it. Honors LVDS_TX_CRC_EN.
module tb_lvds_tx_framer_gearbox;
  import lvds_link_pkg::*;

  localparam logic [9:0] TRAIN = 10'h3A6;
  localparam logic [9:0] SOL   = 10'h2AA;
  localparam logic [9:0] EOLW  = 10'h155;
  localparam logic [9:0] FILL  = 10'h000;

  logic       gclk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] ser_data;
  logic       underrun;
  logic       line_done;

  lvds_tx_framer_gearbox_if pif();

  lvds_tx_framer_gearbox dut (
    .gclk      (gclk),
    .rst_n     (rst_n),
    .pix_if    (pif),
    .ser_data  (ser_data),
    .underrun  (underrun),
    .line_done (line_done)
  );

  always #5 gclk = ~gclk;

  typedef struct packed { logic [9:0] data; logic last; } pix_t;

  pix_t       pix_q[$];
  logic [9:0] exp_q[$];
  logic [5:0] chunk_q[$];

  int tests = 0;
  int fails = 0;
  int k, ms;
  logic [9:0] msum;
  bit src_en, drop_pending;
  int dut_acc, und_cnt, ld_cnt, rdy_err, rdy_high;

  function automatic logic [9:0] obs_word(int i);
    logic [9:0] w;
    int idx;
    w = '0;
    for (int b = 0; b < 10; b++) begin
      idx = i * 10 + b;
      w[b] = chunk_q[idx / 6][idx % 6];
    end
    return w;
  endfunction

  function automatic int obs_words();
    return (chunk_q.size() * 6) / 10;
  endfunction

  // Release reset at a negedge and clear bench state; stream starts at k=0.
  task automatic start_run();
    rst_n = 1'b0;
    pif.s_valid = 1'b0; pif.s_data = '0; pif.s_last = 1'b0;
    @(posedge gclk); @(negedge gclk);
    rst_n = 1'b1;
    pix_q.delete(); exp_q.delete(); chunk_q.delete();
    k = 0; ms = 0; msum = '0; src_en = 1'b0; drop_pending = 1'b0;
    dut_acc = 0; und_cnt = 0; ld_cnt = 0; rdy_err = 0; rdy_high = 0;
  endtask

  // One gclk cycle: drive source, run model, capture outputs at negedge.
  task automatic tick();
    bit slot, v;
    pix_t h;
    slot = (k % 5 == 0) || (k % 5 == 1) || (k % 5 == 3);
    v = src_en && (pix_q.size() > 0);
    if (v && drop_pending && dut_acc >= 1 && slot && ms == 1) begin
      v = 1'b0;
      drop_pending = 1'b0;
    end
    h = (pix_q.size() > 0) ? pix_q[0] : '0;
    pif.s_valid = v;
    pif.s_data  = v ? h.data : 10'h000;
    pif.s_last  = v & h.last;
    #1;
    if (pif.s_ready !== (slot && ms == 1)) rdy_err++;
    if (pif.s_ready === 1'b1) rdy_high++;
    if (v && pif.s_ready === 1'b1) begin
      dut_acc++;
      void'(pix_q.pop_front());
    end
    if (slot) begin
      case (ms)
        0: if (v) begin exp_q.push_back(SOL); msum = '0; ms = 1; end
           else exp_q.push_back(TRAIN);
        1: if (v) begin
             exp_q.push_back(h.data);
             msum = msum + h.data;
             if (h.last) ms = 2;
           end else exp_q.push_back(FILL);
        2: begin
             exp_q.push_back(EOLW);
`ifdef LVDS_TX_CRC_EN
             ms = 3;
`else
             ms = 0;
`endif
           end
        default: begin exp_q.push_back(msum); ms = 0; end
      endcase
    end
    @(posedge gclk); @(negedge gclk);
    chunk_q.push_back(ser_data);
    if (underrun === 1'b1) und_cnt++;
    if (line_done === 1'b1) ld_cnt++;
    k++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pif.s_valid = 1'b1; pif.s_data = 10'h3FF; pif.s_last = 1'b1;
    @(posedge gclk); @(negedge gclk);
    tests++; if (ser_data !== 6'h00) begin fails++; $display("FAIL reset_ser got %h exp 00", ser_data); end
    tests++; if (pif.s_ready !== 1'b0) begin fails++; $display("FAIL reset_ready got %b exp 0", pif.s_ready); end
    tests++; if (underrun !== 1'b0) begin fails++; $display("FAIL reset_underrun got %b exp 0", underrun); end
    tests++; if (line_done !== 1'b0) begin fails++; $display("FAIL reset_line_done got %b exp 0", line_done); end
  endtask

  task automatic test_idle();
    logic [5:0] pat [5];
    logic [9:0] e;
    int n;
    pat[0] = 6'h26; pat[1] = 6'h2E; pat[2] = 6'h29; pat[3] = 6'h1B; pat[4] = 6'h3A;
    start_run();
    repeat (25) tick();
    for (int i = 0; i < 10; i++) begin
      tests++;
      if (chunk_q[i] !== pat[i % 5]) begin
        fails++; $display("FAIL idle_chunk%0d got %h exp %h", i, chunk_q[i], pat[i % 5]);
      end
    end
    tests++; if (rdy_high !== 0) begin fails++; $display("FAIL idle_ready got %0d high cycles exp 0", rdy_high); end
    n = obs_words();
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL idle_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask

  task automatic test_line();
    logic [9:0] seq [6];
    logic [9:0] e;
    int n;
    seq[0] = SOL; seq[1] = 10'h001; seq[2] = 10'h002; seq[3] = 10'h003; seq[4] = 10'h004; seq[5] = EOLW;
    start_run();
    for (int i = 1; i <= 4; i++) pix_q.push_back('{data: 10'(i), last: (i == 4)});
    src_en = 1'b1;
    repeat (30) tick();
    n = obs_words();
    tests++; if (n < 12) begin fails++; $display("FAIL line_wordcount got %0d exp >=12", n); end
    else for (int i = 0; i < 6; i++) begin
      tests++;
      if (obs_word(i) !== seq[i]) begin fails++; $display("FAIL line_seq%0d got %h exp %h", i, obs_word(i), seq[i]); end
    end
    tests++; if (dut_acc !== 4) begin fails++; $display("FAIL line_accepts got %0d exp 4", dut_acc); end
    tests++; if (ld_cnt !== 1) begin fails++; $display("FAIL line_done_pulses got %0d exp 1", ld_cnt); end
    tests++; if (rdy_err !== 0) begin fails++; $display("FAIL line_ready got %0d bad cycles exp 0", rdy_err); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL line_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask

  task automatic test_underrun();
    logic [9:0] seq [6];
    logic [9:0] e;
    int n;
    seq[0] = SOL; seq[1] = 10'h011; seq[2] = FILL; seq[3] = 10'h022; seq[4] = 10'h033; seq[5] = EOLW;
    start_run();
    pix_q.push_back('{data: 10'h011, last: 1'b0});
    pix_q.push_back('{data: 10'h022, last: 1'b0});
    pix_q.push_back('{data: 10'h033, last: 1'b1});
    src_en = 1'b1; drop_pending = 1'b1;
    repeat (30) tick();
    n = obs_words();
    tests++; if (n < 12) begin fails++; $display("FAIL und_wordcount got %0d exp >=12", n); end
    else for (int i = 0; i < 6; i++) begin
      tests++;
      if (obs_word(i) !== seq[i]) begin fails++; $display("FAIL und_seq%0d got %h exp %h", i, obs_word(i), seq[i]); end
    end
    tests++; if (und_cnt !== 1) begin fails++; $display("FAIL und_pulses got %0d exp 1", und_cnt); end
    tests++; if (dut_acc !== 3) begin fails++; $display("FAIL und_accepts got %0d exp 3", dut_acc); end
    tests++; if (ld_cnt !== 1) begin fails++; $display("FAIL und_line_done got %0d exp 1", ld_cnt); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL und_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask

`ifdef LVDS_TX_CRC_EN
  task automatic test_crc();
    logic [9:0] e;
    int n;
    start_run();
    pix_q.push_back('{data: 10'h3FF, last: 1'b0});
    pix_q.push_back('{data: 10'h002, last: 1'b1});
    src_en = 1'b1;
    repeat (20) tick();
    n = obs_words();
    tests++; if (n < 6) begin fails++; $display("FAIL crc_wordcount got %0d exp >=6", n); end
    else begin
      tests++; if (obs_word(3) !== EOLW) begin fails++; $display("FAIL crc_eol got %h exp %h", obs_word(3), EOLW); end
      tests++; if (obs_word(4) !== 10'h001) begin fails++; $display("FAIL crc_word got %h exp 001", obs_word(4)); end
    end
    tests++; if (ld_cnt !== 1) begin fails++; $display("FAIL crc_line_done got %0d exp 1", ld_cnt); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL crc_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    logic [9:0] e;
    int n;
    bit found;
    start_run();
    for (int i = 1; i <= 20; i++) pix_q.push_back('{data: 10'(i + 8'h40), last: (i == 20)});
    src_en = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 40 && !found; c++) begin
      if (dut_acc >= 1 && ms == 1 && (k % 5) == 2) found = 1'b1;
      else tick();
    end
    tests++;
    if (!found) begin fails++; $display("FAIL rstmid_reach got 0 exp 1"); end
    rst_n = 1'b0; pif.s_valid = 1'b0;
    @(posedge gclk); @(negedge gclk);
    tests++; if (pif.s_ready !== 1'b0) begin fails++; $display("FAIL rstmid_ready got %b exp 0", pif.s_ready); end
    tests++; if (ser_data !== 6'h00) begin fails++; $display("FAIL rstmid_ser got %h exp 00", ser_data); end
    start_run();
    repeat (15) tick();
    tests++; if (chunk_q[0] !== 6'h26) begin fails++; $display("FAIL rstmid_restart got %h exp 26", chunk_q[0]); end
    n = obs_words();
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL rstmid_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask

  task automatic test_back_to_back();
    logic [9:0] e;
    int n, idx, nxt;
    start_run();
    for (int i = 1; i <= 3; i++) pix_q.push_back('{data: 10'h100 + 10'(i), last: (i == 3)});
    for (int i = 1; i <= 3; i++) pix_q.push_back('{data: 10'h200 + 10'(i), last: (i == 3)});
    src_en = 1'b1;
    repeat (30) tick();
    n = obs_words();
    idx = -1;
    for (int i = 0; i < n && idx < 0; i++) if (obs_word(i) === EOLW) idx = i;
`ifdef LVDS_TX_CRC_EN
    nxt = idx + 2;
`else
    nxt = idx + 1;
`endif
    tests++;
    if (idx < 0 || nxt >= n) begin fails++; $display("FAIL b2b_eol_found got %0d exp >=0", idx); end
    else if (obs_word(nxt) !== SOL) begin fails++; $display("FAIL b2b_next_sol got %h exp %h", obs_word(nxt), SOL); end
    tests++; if (dut_acc !== 6) begin fails++; $display("FAIL b2b_accepts got %0d exp 6", dut_acc); end
    tests++; if (ld_cnt !== 2) begin fails++; $display("FAIL b2b_line_done got %0d exp 2", ld_cnt); end
    for (int i = 0; i < n && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front(); tests++;
      if (obs_word(i) !== e) begin fails++; $display("FAIL b2b_word%0d got %h exp %h", i, obs_word(i), e); end
    end
  endtask

  initial begin
    pif.s_valid = 1'b0; pif.s_data = '0; pif.s_last = 1'b0;
    @(negedge gclk);
    test_reset();
    test_idle();
    test_line();
    test_underrun();
`ifdef LVDS_TX_CRC_EN
    test_crc();
`endif
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
